// File: rtl/wall_probe_arbiter.sv
// ---------------------------------------------------------------------------
// wall_probe_arbiter
//
// Shares one combinational wall lookup between several sprite movement
// controllers (requester 0 = Pac-Man, 1..N_REQ-1 = ghosts). A granted
// requester's candidate top-left position is latched. The four corners of its
// SPRITE_W x SPRITE_W box are then probed one per cycle, and the ORed result
// is written into that requester's blocked bit.
//
// Ports
//   Clk         system clock
//   Reset_n     asynchronous active-low reset
//   req         per-requester check request (level)
//   req_x/req_y packed 10-bit candidate top-left coordinates, requester i
//               uses bits [10i+9:10i]
//   ack         one-cycle pulse when requester i's result has been written
//   blocked     per-requester result, 1 = box touches a wall (all ones
//               after reset)
//   busy        a check is in progress
//   probe_x/y   coordinate presented to the wall lookup (0 when not probing)
//   probe_wall  wall lookup result for (probe_x, probe_y), same cycle
// ---------------------------------------------------------------------------
module wall_probe_arbiter #(
    parameter int N_REQ    = 5,
    parameter int SPRITE_W = 24
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [10*N_REQ-1:0]  req_x,
    input  logic [10*N_REQ-1:0]  req_y,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     blocked,
    output logic                 busy,
    output logic [9:0]           probe_x,
    output logic [9:0]           probe_y,
    input  logic                 probe_wall
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [10:0] EDGE_OFS = 11'(SPRITE_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [GW-1:0]     last_grant_reg;
    logic [GW-1:0]     grant_reg;
    logic [GW-1:0]     grant_next;
    logic              grant_valid;
    logic [9:0]        cx_reg, cy_reg;
    logic              acc_reg;
    logic [1:0]        corner_reg;
    logic [N_REQ-1:0]  blocked_reg;
    logic [10:0]       sum_x, sum_y;

    // Round-robin search: first set req bit starting at last_grant+1.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_next  = last_grant_reg;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant_reg) + k) % N_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_next  = GW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = PROBE;
            PROBE:   if (corner_reg == 2'd3) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: coordinate latch, corner walk, wall accumulator, results
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant_reg <= GW'(N_REQ - 1);
            grant_reg      <= '0;
            cx_reg         <= '0;
            cy_reg         <= '0;
            acc_reg        <= 1'b0;
            corner_reg     <= 2'd0;
            blocked_reg    <= '1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        grant_reg  <= grant_next;
                        cx_reg     <= req_x[10*grant_next +: 10];
                        cy_reg     <= req_y[10*grant_next +: 10];
                        acc_reg    <= 1'b0;
                        corner_reg <= 2'd0;
                    end
                end
                PROBE: begin
                    acc_reg    <= acc_reg | probe_wall;
                    corner_reg <= corner_reg + 2'd1;
                    // Result includes the last corner sampled this cycle.
                    if (corner_reg == 2'd3) begin
                        blocked_reg[grant_reg] <= acc_reg | probe_wall;
                    end
                end
                DONE: begin
                    last_grant_reg <= grant_reg;
                end
                default: ;
            endcase
        end
    end

    // Corner coordinates in 11 bits; bit 10 set means the box edge ran past
    // the 10-bit range, which saturates to 1023 (off-maze, reads as wall).
    assign sum_x = {1'b0, cx_reg} + (corner_reg[0] ? EDGE_OFS : 11'd0);
    assign sum_y = {1'b0, cy_reg} + (corner_reg[1] ? EDGE_OFS : 11'd0);

    // Outputs
    always_comb begin
        ack     = '0;
        busy    = (state_reg != IDLE);
        probe_x = 10'd0;
        probe_y = 10'd0;
        if (state_reg == PROBE) begin
            probe_x = sum_x[10] ? 10'h3FF : sum_x[9:0];
            probe_y = sum_y[10] ? 10'h3FF : sum_y[9:0];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (state_reg == DONE && grant_reg == GW'(i)) ack[i] = 1'b1;
        end
    end

    assign blocked = blocked_reg;

endmodule

// File: tb/tb_wall_probe_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wall_probe_arbiter
//
// Self-checking bench. A small maze model answers probe_wall. Each driven
// request pushes its expected ack (requester, blocked bit, cycle) onto a
// scoreboard. It may also push the expected corner probe sequence. A
// negedge monitor pops and compares these when the DUT acks or probes.
// ---------------------------------------------------------------------------
module tb_wall_probe_arbiter;

    localparam int N_REQ    = 5;
    localparam int SPRITE_W = 24;

    logic                Clk;
    logic                Reset_n;
    logic [N_REQ-1:0]    req;
    logic [10*N_REQ-1:0] req_x;
    logic [10*N_REQ-1:0] req_y;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ-1:0]    blocked;
    logic                busy;
    logic [9:0]          probe_x;
    logic [9:0]          probe_y;
    logic                probe_wall;

    typedef struct {
        int   idx;
        logic blk;
        int   cyc;
    } sb_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } pr_t;

    sb_t              sbq[$];
    pr_t              pq[$];
    logic [N_REQ-1:0] exp_blocked;
    int               cyc;
    int               n_checks;
    int               n_pass;
    int               busy_cnt;

    wall_probe_arbiter #(.N_REQ(N_REQ), .SPRITE_W(SPRITE_W)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .ack        (ack),
        .blocked    (blocked),
        .busy       (busy),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .probe_wall (probe_wall)
    );

    // Maze model: off-maze (x>=640 or y>=480) and one square block
    // spanning x 192..223, y 80..111 are walls.
    function automatic logic wall_at(input logic [9:0] x, input logic [9:0] y);
        if (x >= 10'd640 || y >= 10'd480) return 1'b1;
        if (x >= 10'd192 && x <= 10'd223 && y >= 10'd80 && y <= 10'd111) return 1'b1;
        return 1'b0;
    endfunction

    assign probe_wall = wall_at(probe_x, probe_y);

    function automatic logic [9:0] far_edge(input int c);
        int s;
        s = c + SPRITE_W - 1;
        if (s > 1023) s = 1023;
        return 10'(s);
    endfunction

    function automatic logic box_blocked(input int x, input int y);
        logic [9:0] x0, y0, x1, y1;
        x0 = 10'(x);
        y0 = 10'(y);
        x1 = far_edge(x);
        y1 = far_edge(y);
        return wall_at(x0, y0) | wall_at(x1, y0) | wall_at(x0, y1) | wall_at(x1, y1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push_probes(input int x, input int y);
        pr_t p;
        p.x = 10'(x);        p.y = 10'(y);        pq.push_back(p);
        p.x = far_edge(x);   p.y = 10'(y);        pq.push_back(p);
        p.x = 10'(x);        p.y = far_edge(y);   pq.push_back(p);
        p.x = far_edge(x);   p.y = far_edge(y);   pq.push_back(p);
    endtask

    task automatic push_ack(input int idx, input int x, input int y, input int at_cyc);
        sb_t e;
        e.idx = idx;
        e.blk = box_blocked(x, y);
        e.cyc = at_cyc;
        sbq.push_back(e);
    endtask

    task automatic set_coord(input int idx, input int x, input int y);
        req_x[10*idx +: 10] = 10'(x);
        req_y[10*idx +: 10] = 10'(y);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80; i++) begin
            if (sbq.size() == 0) break;
            @(posedge Clk); #1;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    // One isolated check; optionally moves the coordinates in cycle 2.
    task automatic run_one(input int idx, input int x, input int y, input bit move);
        @(posedge Clk); #1;
        set_coord(idx, x, y);
        req[idx] = 1'b1;
        push_ack(idx, x, y, cyc + 5);
        push_probes(x, y);
        @(posedge Clk); #1;
        req[idx] = 1'b0;
        if (move) begin
            @(posedge Clk); #1;
            set_coord(idx, 180, 60);
        end
        wait_drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blocked"}, 32'(blocked), 32'h1F);
        check({tag, "_ack"},     32'(ack),     32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_probe_x"}, 32'(probe_x), 32'd0);
        check({tag, "_probe_y"}, 32'(probe_y), 32'd0);
        exp_blocked = '1;
        pq.delete();
        sbq.delete();
    endtask

    // Clock and cycle counter
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge Clk);
            cyc++;
        end
    end

    // Monitor: ack scoreboard and probe sequence
    initial begin
        busy_cnt = 0;
        forever begin
            @(negedge Clk);
            if (busy && Reset_n) begin
                busy_cnt++;
                if (busy_cnt <= 4 && pq.size() != 0) begin
                    pr_t p;
                    p = pq.pop_front();
                    check($sformatf("probe_x_c%0d", busy_cnt - 1), 32'(probe_x), 32'(p.x));
                    check($sformatf("probe_y_c%0d", busy_cnt - 1), 32'(probe_y), 32'(p.y));
                end
            end else begin
                busy_cnt = 0;
            end
            if (ack != '0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    exp_blocked[e.idx] = e.blk;
                    $display("ack req=%0d blocked=%b cycle=%0d", e.idx, blocked, cyc);
                    check("ack_vector", 32'(ack), 32'(1) << e.idx);
                    check("blocked_vector", 32'(blocked), 32'(exp_blocked));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Stimulus
    initial begin
        int c0;
        n_checks    = 0;
        n_pass      = 0;
        exp_blocked = '1;
        Reset_n     = 1'b0;
        req         = '0;
        req_x       = '0;
        req_y       = '0;

        // Reset values, then a clear corridor check for requester 0
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        run_one(0, 164, 52, 1'b0);

        // Wall hit on corner 3
        run_one(2, 180, 60, 1'b0);

        // Saturation on both axes
        run_one(1, 1010, 1010, 1'b0);

        // Coordinates latched at grant; later changes ignored
        run_one(3, 164, 52, 1'b1);

        // Round-robin with everyone requesting from reset
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("rr_reset");
        set_coord(0, 164, 52);
        set_coord(1, 180, 60);
        set_coord(2, 1010, 1010);
        set_coord(3, 100, 100);
        set_coord(4, 200, 90);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        req     = '1;
        c0      = cyc;
        push_ack(0, 164, 52, c0 + 5);
        push_ack(1, 180, 60, c0 + 11);
        push_ack(2, 1010, 1010, c0 + 17);
        push_ack(3, 100, 100, c0 + 23);
        push_ack(4, 200, 90, c0 + 29);
        push_ack(0, 164, 52, c0 + 35);
        wait_drain();
        req = '0;
        repeat (2) @(posedge Clk);

        // Asynchronous reset in cycle 3 of a check: no ack, back to reset state
        @(posedge Clk); #1;
        set_coord(4, 164, 52);
        req[4] = 1'b1;
        @(posedge Clk); #1;
        req[4] = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        #1;
        Reset_n = 1'b1;
        repeat (8) @(posedge Clk);
        #1;
        check("midreset_busy_after", 32'(busy), 32'd0);

        // Requesters 0 and 2 together: 0 must win first after reset
        set_coord(0, 164, 52);
        set_coord(2, 180, 60);
        req = 5'b00101;
        c0  = cyc;
        push_ack(0, 164, 52, c0 + 5);
        push_ack(2, 180, 60, c0 + 11);
        @(posedge Clk); #1;
        req = 5'b00100;
        repeat (6) @(posedge Clk);
        #1;
        req = '0;
        wait_drain();
        repeat (3) @(posedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
